mux_scan_sequencer: RTL and testbench

Sequencer that drives the 2-bit select of the 4:1 reset-able multiplexor stage and consumes its 1-bit output. On a start request it steps through the enabled channels, waits a programmable settle time per channel, samples the mux output and assembles the results into a 4-bit word. The word is then offered downstream with a valid/ready handshake. It sits directly around the mux: `o_con` feeds the mux select, and the mux output returns on `i_mux`.

---
 rtl/mux_scan_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Purpose:
//   Drives the 2-bit select of a 4:1 mux stage and samples its 1-bit output.
//   On a start request it walks the enabled channels in ascending order. For
//   each channel it waits DWELL settle cycles and then samples for one cycle.
//   The results are packed into a 4-bit word, which is then offered downstream
//   with a valid/ready handshake.
//
// Parameters:
//   DWELL    settle cycles per channel before sampling (1..255)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rs       in   1  synchronous active-high reset
//   i_start  in   1  scan request, only honoured in IDLE
//   i_mask   in   4  channel enables, latched when the start is accepted
//   i_mux    in   1  mux output for the channel currently selected by o_con
//   o_con    out  2  mux select (channel index)
//   o_word   out  4  scan result, bit n = sample of channel n (0 if disabled)
//   o_valid  out  1  result available
//   i_ready  in   1  downstream accepts the result (only looked at in DONE)
//   o_busy   out  1  high whenever the sequencer is not idle
module mux_scan_sequencer #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       i_start,
    input  logic [3:0] i_mask,
    input  logic       i_mux,
    output logic [1:0] o_con,
    output logic [3:0] o_word,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [1:0] r_state;
    logic [1:0] r_con;
    logic [3:0] r_word;
    logic       r_valid;
    logic       r_busy;
    logic [7:0] r_count;
    logic [3:0] r_mask;

    logic [1:0] w_firstCh;
    logic [1:0] w_nextCh;
    logic       w_hasNext;

    // Lowest enabled channel of the incoming mask. For an empty mask the
    // select is left where it is, so this falls back to the current value.
    always_comb begin
        w_firstCh = r_con;
        if (i_mask[0])
            w_firstCh = 2'd0;
        else if (i_mask[1])
            w_firstCh = 2'd1;
        else if (i_mask[2])
            w_firstCh = 2'd2;
        else if (i_mask[3])
            w_firstCh = 2'd3;
    end

    // Next enabled channel strictly above the current one in the latched
    // mask. Disabled channels are skipped here, so they never cost a cycle.
    always_comb begin
        w_hasNext = 1'b0;
        w_nextCh  = r_con;
        case (r_con)
            2'd0: begin
                if (r_mask[1]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd1;
                end else if (r_mask[2]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd2;
                end else if (r_mask[3]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd3;
                end
            end
            2'd1: begin
                if (r_mask[2]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd2;
                end else if (r_mask[3]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd3;
                end
            end
            2'd2: begin
                if (r_mask[3]) begin
                    w_hasNext = 1'b1;
                    w_nextCh  = 2'd3;
                end
            end
            default: begin
                w_hasNext = 1'b0;
                w_nextCh  = r_con;
            end
        endcase
    end

    // Scan state machine. All outputs are registered here.
    // An empty mask still passes once through SAMPLE. With no enabled
    // channel, nothing is written, and the empty result appears one edge
    // after the start. The write is gated by the latched mask so that this
    // pass cannot disturb the cleared word.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_state <= S_IDLE;
            r_con   <= 2'b00;
            r_word  <= 4'b0000;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= 8'd0;
            r_mask  <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask  <= i_mask;
                        r_word  <= 4'b0000;
                        r_busy  <= 1'b1;
                        r_count <= 8'd0;
                        if (|i_mask) begin
                            r_con   <= w_firstCh;
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end
                S_SETTLE: begin
                    r_count <= r_count + 8'd1;
                    if (r_count == DWELL_LAST)
                        r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (r_mask[r_con])
                        r_word[r_con] <= i_mux;
                    if (w_hasNext) begin
                        r_con   <= w_nextCh;
                        r_count <= 8'd0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_con   = r_con;
    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer.
// It models the 4:1 mux as a lookup of the bench-driven channel values, using
// the DUT select. Each scan pushes an expectation onto a scoreboard queue when
// the start is driven. The entry is popped and compared when o_valid rises.
module tb_mux_scan_sequencer;

    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rs;
    logic       i_start;
    logic [3:0] i_mask;
    logic       i_mux;
    logic [1:0] o_con;
    logic [3:0] o_word;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;

    logic [3:0] muxIn;
    logic [1:0] modelCon;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] bits;
        logic [3:0] expWord;
        int         expLat;
        int         hold;
    } vector_t;

    typedef struct {
        logic [3:0] word;
        int         lat;
        logic [1:0] trace [16];
        int         traceLen;
        logic [1:0] conEnd;
    } scoreEntry_t;

    scoreEntry_t sbQueue [$];
    vector_t     vectors [6];

    // Free-running clock
    always #5 clk = ~clk;

    // The mux stage itself: combinational select of the channel values
    assign i_mux = muxIn[o_con];

    mux_scan_sequencer #(.DWELL(DWELL)) dut (
        .clk     (clk),
        .rs      (rs),
        .i_start (i_start),
        .i_mask  (i_mask),
        .i_mux   (i_mux),
        .o_con   (o_con),
        .o_word  (o_word),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".o_con"},   o_con,   2'b00);
        checkOutput({tag, ".o_word"},  o_word,  4'b0000);
        checkOutput({tag, ".o_valid"}, o_valid, 1'b0);
        checkOutput({tag, ".o_busy"},  o_busy,  1'b0);
    endtask

    // Runs one scan from IDLE. The expected select trace is built from the
    // mask: each enabled channel is held DWELL+1 cycles, in ascending order.
    task automatic applyStimulus(input vector_t v);
        scoreEntry_t e;
        scoreEntry_t got;
        logic [1:0]  trace [16];
        int          tlen;
        int          n;
        int          traceErr;

        e.word     = v.expWord;
        e.lat      = v.expLat;
        e.traceLen = 0;
        e.conEnd   = modelCon;
        for (int ch = 0; ch < 4; ch++) begin
            if (v.mask[ch]) begin
                for (int r = 0; r <= DWELL; r++) begin
                    e.trace[e.traceLen] = 2'(ch);
                    e.traceLen++;
                end
                e.conEnd = 2'(ch);
            end
        end
        if (e.traceLen == 0) begin
            e.trace[0] = modelCon;
            e.traceLen = 1;
        end

        @(negedge clk);
        i_mask  = v.mask;
        muxIn   = v.bits;
        i_start = 1'b1;
        sbQueue.push_back(e);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_mask  = ~v.mask;
        if (v.hold > 0)
            i_ready = 1'b0;
        checkOutput("busyAfterStart", o_busy, 1'b1);

        n    = 0;
        tlen = 0;
        while (!o_valid && n < 64) begin
            if (tlen < 16) begin
                trace[tlen] = o_con;
                tlen++;
            end
            @(negedge clk);
            n++;
        end

        got = sbQueue.pop_front();
        checkOutput("validSeen", o_valid, 1'b1);
        checkOutput("latency", n, got.lat);
        checkOutput("word", o_word, got.word);
        checkOutput("conAtDone", o_con, got.conEnd);
        traceErr = (tlen == got.traceLen) ? 0 : 1;
        for (int i = 0; i < 16; i++)
            if (i < tlen && i < got.traceLen && trace[i] !== got.trace[i])
                traceErr++;
        checkOutput("conTrace", traceErr, 0);

        if (v.hold > 0) begin
            i_start = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                checkOutput("holdValid", o_valid, 1'b1);
                checkOutput("holdWord", o_word, got.word);
                checkOutput("holdBusy", o_busy, 1'b1);
            end
            i_ready = 1'b1;
        end
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("validDropped", o_valid, 1'b0);
        checkOutput("idleAfterHandshake", o_busy, 1'b0);
        modelCon = got.conEnd;
    endtask

    initial begin
        int validSeen;

        // channel values a..d = bit0..bit3
        vectors[0] = '{mask: 4'b1111, bits: 4'b1101, expWord: 4'b1101, expLat: 12, hold: 0};
        vectors[1] = '{mask: 4'b1010, bits: 4'b1111, expWord: 4'b1010, expLat: 6,  hold: 0};
        vectors[2] = '{mask: 4'b0000, bits: 4'b1111, expWord: 4'b0000, expLat: 1,  hold: 0};
        vectors[3] = '{mask: 4'b0110, bits: 4'b0100, expWord: 4'b0100, expLat: 6,  hold: 5};
        vectors[4] = '{mask: 4'b1000, bits: 4'b1000, expWord: 4'b1000, expLat: 3,  hold: 0};
        vectors[5] = '{mask: 4'b0001, bits: 4'b0001, expWord: 4'b0001, expLat: 3,  hold: 0};

        rs       = 1'b1;
        i_start  = 1'b1;
        i_mask   = 4'b1111;
        i_ready  = 1'b1;
        muxIn    = 4'b0000;
        modelCon = 2'b00;

        // Reset held with a start request pending
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkResetOutputs("reset");
        end
        rs      = 1'b0;
        i_start = 1'b0;

        for (int i = 0; i < 6; i++)
            applyStimulus(vectors[i]);

        // Reset four edges into a full scan
        @(negedge clk);
        i_mask  = 4'b1111;
        muxIn   = 4'b1111;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        rs = 1'b1;
        @(negedge clk);
        rs = 1'b0;
        checkResetOutputs("midScanReset");
        modelCon  = 2'b00;
        validSeen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_valid)
                validSeen++;
        end
        checkOutput("noValidAfterReset", validSeen, 0);

        applyStimulus(vectors[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
